// File: rtl/wave_pkg.sv
// Shared parameters and clear-engine state encoding for the wave sample RAM arbiter.
package wave_pkg;

    localparam int                P_ADDR_W    = 15;
    localparam int                P_DATA_W    = 16;
    localparam int                P_DEPTH     = 32768;
    localparam logic [15:0]       P_CLEAR_VAL = 16'd400;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_DONE  = 2'd2
    } clr_state_t;

endpackage

// File: rtl/wave_clear_fsm.sv
// Clear engine: walks every RAM word once, issuing a write per unstalled cycle.
// Latency: first write the cycle after the request; done pulses one cycle after the last write.
// Backpressure: stall freezes the counter and suppresses the write strobe.
module wave_clear_fsm #(
    parameter int P_ADDR_W = wave_pkg::P_ADDR_W,
    parameter int P_DEPTH  = wave_pkg::P_DEPTH
) (
    input  logic                I_sys_clk,
    input  logic                I_reset,
    input  logic                clear_req,
    input  logic                stall,
    output logic                clear_busy,
    output logic                clear_done,
    output logic [P_ADDR_W-1:0] clr_addr,
    output logic                clr_we
);
    import wave_pkg::*;

    // One extra bit so a full 2**P_ADDR_W clear reaches its last index without wrapping.
    localparam logic [P_ADDR_W:0] C_LAST = (P_ADDR_W + 1)'(P_DEPTH - 1);

    clr_state_t          state;
    logic [P_ADDR_W:0]   cnt;

    always_ff @(posedge I_sys_clk) begin
        if (I_reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            clear_busy <= 1'b0;
            clear_done <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (clear_req) begin
                        state      <= S_CLEAR;
                        cnt        <= '0;
                        clear_busy <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    if (!stall) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == C_LAST) begin
                            state      <= S_DONE;
                            clear_busy <= 1'b0;
                            clear_done <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state      <= S_IDLE;
                    clear_done <= 1'b0;
                end
                default: begin
                    state      <= S_IDLE;
                    clear_busy <= 1'b0;
                    clear_done <= 1'b0;
                end
            endcase
        end
    end

    assign clr_addr = cnt[P_ADDR_W-1:0];
    assign clr_we   = clear_busy & ~stall;

endmodule

// File: rtl/wave_ram_arbiter.sv
// Single-port wave RAM arbiter: display read > clear engine > capture write, one access per cycle.
// Latency: read data valid exactly P_RD_LAT cycles after I_rd_en; reads are never blocked.
// Backpressure: O_wr_ready drops on any read cycle and for the whole clear; requester holds its write.
module wave_ram_arbiter #(
    parameter int                        P_ADDR_W    = wave_pkg::P_ADDR_W,
    parameter int                        P_DATA_W    = wave_pkg::P_DATA_W,
    parameter int                        P_DEPTH     = wave_pkg::P_DEPTH,
    parameter logic [P_DATA_W-1:0]       P_CLEAR_VAL = P_DATA_W'(wave_pkg::P_CLEAR_VAL),
    parameter int                        P_RD_LAT    = 1
) (
    input  logic                I_sys_clk,
    input  logic                I_reset,
    input  logic                I_clear_req,
    output logic                O_clear_busy,
    output logic                O_clear_done,
    input  logic                I_rd_en,
    input  logic [P_ADDR_W-1:0] I_rd_addr,
    output logic [P_DATA_W-1:0] O_rd_data,
    output logic                O_rd_valid,
    input  logic                I_wr_valid,
    input  logic [P_ADDR_W-1:0] I_wr_addr,
    input  logic [P_DATA_W-1:0] I_wr_data,
    output logic                O_wr_ready,
    output logic [P_ADDR_W-1:0] O_ram_addr,
    output logic                O_ram_we,
    output logic [P_DATA_W-1:0] O_ram_din,
    input  logic [P_DATA_W-1:0] I_ram_dout
);
    import wave_pkg::*;

    logic [P_ADDR_W-1:0] clr_addr;
    logic                clr_we;
    logic [P_ADDR_W-1:0] last_rd_addr;
    logic [P_RD_LAT-1:0] vld_pipe;

    wave_clear_fsm #(
        .P_ADDR_W (P_ADDR_W),
        .P_DEPTH  (P_DEPTH)
    ) u_clear_fsm (
        .I_sys_clk  (I_sys_clk),
        .I_reset    (I_reset),
        .clear_req  (I_clear_req),
        .stall      (I_rd_en),
        .clear_busy (O_clear_busy),
        .clear_done (O_clear_done),
        .clr_addr   (clr_addr),
        .clr_we     (clr_we)
    );

    always_ff @(posedge I_sys_clk) begin
        if (I_reset) begin
            last_rd_addr <= '0;
            vld_pipe     <= '0;
        end else begin
            if (I_rd_en) begin
                last_rd_addr <= I_rd_addr;
            end
            vld_pipe <= (vld_pipe << 1) | P_RD_LAT'(I_rd_en);
        end
    end

    assign O_rd_valid = vld_pipe[P_RD_LAT-1];
    assign O_rd_data  = O_rd_valid ? I_ram_dout : '0;
    assign O_wr_ready = ~I_reset & ~I_rd_en & ~O_clear_busy;

    // Idle cycles keep the last read address on the bus to avoid needless address toggling.
    always_comb begin
        O_ram_addr = last_rd_addr;
        O_ram_we   = 1'b0;
        O_ram_din  = '0;
        if (I_rd_en) begin
            O_ram_addr = I_rd_addr;
        end else if (clr_we) begin
            O_ram_addr = clr_addr;
            O_ram_we   = 1'b1;
            O_ram_din  = P_CLEAR_VAL;
        end else if (I_wr_valid && O_wr_ready) begin
            O_ram_addr = I_wr_addr;
            O_ram_we   = 1'b1;
            O_ram_din  = I_wr_data;
        end
    end

endmodule

// File: tb/tb_wave_ram_arbiter.sv
// Bench for wave_ram_arbiter: directed vector table plus clear / abort / full-clear sequences.
module tb_wave_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear_req;
    logic        clear_busy;
    logic        clear_done;
    logic        rd_en;
    logic [14:0] rd_addr;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        wr_valid;
    logic [14:0] wr_addr;
    logic [15:0] wr_data;
    logic        wr_ready;
    logic [14:0] ram_addr;
    logic        ram_we;
    logic [15:0] ram_din;
    logic [15:0] ram_dout;

    logic [15:0] mem [32768];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    wave_ram_arbiter dut (
        .I_sys_clk    (clk),
        .I_reset      (rst),
        .I_clear_req  (clear_req),
        .O_clear_busy (clear_busy),
        .O_clear_done (clear_done),
        .I_rd_en      (rd_en),
        .I_rd_addr    (rd_addr),
        .O_rd_data    (rd_data),
        .O_rd_valid   (rd_valid),
        .I_wr_valid   (wr_valid),
        .I_wr_addr    (wr_addr),
        .I_wr_data    (wr_data),
        .O_wr_ready   (wr_ready),
        .O_ram_addr   (ram_addr),
        .O_ram_we     (ram_we),
        .O_ram_din    (ram_din),
        .I_ram_dout   (ram_dout)
    );

    // Single-port read-first RAM with one cycle of read latency.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        rd_en;
        logic [14:0] rd_addr;
        logic        wr_valid;
        logic [14:0] wr_addr;
        logic [15:0] wr_data;
        logic        e_we;
        logic [14:0] e_addr;
        logic [15:0] e_din;
        logic        e_rdy;
        logic        e_vld;
        logic [15:0] e_rdata;
    } vec_t;

    function automatic vec_t mk(input logic re, input logic [14:0] ra, input logic wv,
                                input logic [14:0] wa, input logic [15:0] wd,
                                input logic ewe, input logic [14:0] ea, input logic [15:0] ed,
                                input logic erdy, input logic evld, input logic [15:0] erd);
        vec_t v;
        v.rd_en = re; v.rd_addr = ra; v.wr_valid = wv; v.wr_addr = wa; v.wr_data = wd;
        v.e_we = ewe; v.e_addr = ea; v.e_din = ed; v.e_rdy = erdy; v.e_vld = evld; v.e_rdata = erd;
        return v;
    endfunction

    task automatic read_back(input logic [14:0] a, input logic [15:0] exp, input string nm);
        @(posedge clk); #1;
        rd_en = 1'b1; rd_addr = a;
        @(posedge clk); #1;
        rd_en = 1'b0;
        @(negedge clk);
        chk(nm, {rd_valid, rd_data}, {1'b1, exp});
    endtask

    vec_t vt [14];

    initial begin
        int          exp_cnt;
        int          busy_cycles;
        int          done_cnt;
        logic        prev_rd;
        logic        hit;
        logic [15:0] exp_rd;

        for (int i = 0; i < 32768; i++) mem[i] = 16'(i) + 16'h1000;

        // Memory pre-filled with addr + 0x1000, so reads of untouched words are predictable.
        vt[0]  = mk(1'b1, 15'h0010, 1'b0, 15'h0,    16'h0,    1'b0, 15'h0010, 16'h0,    1'b0, 1'b0, 16'h0);
        vt[1]  = mk(1'b1, 15'h0011, 1'b0, 15'h0,    16'h0,    1'b0, 15'h0011, 16'h0,    1'b0, 1'b1, 16'h1010);
        vt[2]  = mk(1'b1, 15'h0012, 1'b0, 15'h0,    16'h0,    1'b0, 15'h0012, 16'h0,    1'b0, 1'b1, 16'h1011);
        vt[3]  = mk(1'b1, 15'h0013, 1'b0, 15'h0,    16'h0,    1'b0, 15'h0013, 16'h0,    1'b0, 1'b1, 16'h1012);
        vt[4]  = mk(1'b0, 15'h0,    1'b1, 15'h0123, 16'hABCD, 1'b1, 15'h0123, 16'hABCD, 1'b1, 1'b1, 16'h1013);
        vt[5]  = mk(1'b0, 15'h0,    1'b0, 15'h0,    16'h0,    1'b0, 15'h0013, 16'h0,    1'b1, 1'b0, 16'h0);
        vt[6]  = mk(1'b1, 15'h0123, 1'b0, 15'h0,    16'h0,    1'b0, 15'h0123, 16'h0,    1'b0, 1'b0, 16'h0);
        vt[7]  = mk(1'b0, 15'h0,    1'b0, 15'h0,    16'h0,    1'b0, 15'h0123, 16'h0,    1'b1, 1'b1, 16'hABCD);
        vt[8]  = mk(1'b1, 15'h0005, 1'b1, 15'h0200, 16'h1234, 1'b0, 15'h0005, 16'h0,    1'b0, 1'b0, 16'h0);
        vt[9]  = mk(1'b1, 15'h0006, 1'b1, 15'h0200, 16'h1234, 1'b0, 15'h0006, 16'h0,    1'b0, 1'b1, 16'h1005);
        vt[10] = mk(1'b1, 15'h0007, 1'b1, 15'h0200, 16'h1234, 1'b0, 15'h0007, 16'h0,    1'b0, 1'b1, 16'h1006);
        vt[11] = mk(1'b0, 15'h0,    1'b1, 15'h0200, 16'h1234, 1'b1, 15'h0200, 16'h1234, 1'b1, 1'b1, 16'h1007);
        vt[12] = mk(1'b1, 15'h0200, 1'b0, 15'h0,    16'h0,    1'b0, 15'h0200, 16'h0,    1'b0, 1'b0, 16'h0);
        vt[13] = mk(1'b0, 15'h0,    1'b0, 15'h0,    16'h0,    1'b0, 15'h0200, 16'h0,    1'b1, 1'b1, 16'h1234);

        rst = 1'b1; clear_req = 1'b0; rd_en = 1'b0; rd_addr = '0;
        wr_valid = 1'b1; wr_addr = 15'h0055; wr_data = 16'h5555;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy",     clear_busy, 1'b0);
        chk("rst_done",     clear_done, 1'b0);
        chk("rst_rd_valid", rd_valid,   1'b0);
        chk("rst_rd_data",  rd_data,    16'h0);
        chk("rst_wr_ready", wr_ready,   1'b0);
        chk("rst_ram_we",   ram_we,     1'b0);

        @(posedge clk); #1;
        rst = 1'b0; wr_valid = 1'b0;

        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1;
            rd_en = vt[i].rd_en; rd_addr = vt[i].rd_addr;
            wr_valid = vt[i].wr_valid; wr_addr = vt[i].wr_addr; wr_data = vt[i].wr_data;
            @(negedge clk);
            chk($sformatf("v%0d_we", i),    ram_we,   vt[i].e_we);
            chk($sformatf("v%0d_addr", i),  ram_addr, vt[i].e_addr);
            if (vt[i].e_we) chk($sformatf("v%0d_din", i), ram_din, vt[i].e_din);
            chk($sformatf("v%0d_rdy", i),   wr_ready, vt[i].e_rdy);
            chk($sformatf("v%0d_vld", i),   rd_valid, vt[i].e_vld);
            chk($sformatf("v%0d_rdata", i), rd_data,  vt[i].e_rdata);
        end

        // Clear with reads on alternate cycles, a repeated request, then reset at counter 1000.
        @(posedge clk); #1;
        rd_en = 1'b0; wr_valid = 1'b0; clear_req = 1'b1;
        exp_cnt = 0; prev_rd = 1'b0; hit = 1'b0; exp_rd = '0;
        for (int k = 0; k < 3000 && !hit; k++) begin
            @(posedge clk); #1;
            clear_req = (k == 40);
            rd_en = k[0]; rd_addr = 15'h4000 + 15'(k);
            wr_valid = 1'b1; wr_addr = 15'h0300; wr_data = 16'hDEAD;
            @(negedge clk);
            if (prev_rd) chk("alt_rd_data", {rd_valid, rd_data}, {1'b1, exp_rd});
            else         chk("alt_rd_idle", rd_valid, 1'b0);
            chk("alt_busy_rdy_done", {clear_busy, wr_ready, clear_done}, 3'b100);
            if (rd_en) begin
                chk("alt_rd_pass", {ram_we, ram_addr}, {1'b0, rd_addr});
                exp_rd = mem[rd_addr];
            end else begin
                chk("alt_clr_wr", {ram_we, ram_addr, ram_din}, {1'b1, 15'(exp_cnt), 16'd400});
                exp_cnt++;
            end
            prev_rd = rd_en;
            if (exp_cnt == 1000) hit = 1'b1;
        end
        chk("alt_reached_1000", hit, 1'b1);

        @(posedge clk); #1;
        rst = 1'b1; rd_en = 1'b1; rd_addr = 15'h0001; wr_valid = 1'b0; clear_req = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort_busy",     clear_busy, 1'b0);
        chk("abort_done",     clear_done, 1'b0);
        chk("abort_rd_valid", rd_valid,   1'b0);

        // Full clear without reads; writes attempted throughout must wait for S_DONE.
        @(posedge clk); #1;
        rst = 1'b0; rd_en = 1'b0; clear_req = 1'b1;
        exp_cnt = 0; busy_cycles = 0; done_cnt = 0;
        for (int k = 0; k < 33000 && done_cnt == 0; k++) begin
            @(posedge clk); #1;
            clear_req = 1'b0;
            wr_valid = 1'b1; wr_addr = 15'h0100; wr_data = 16'hBEEF;
            @(negedge clk);
            if (clear_busy) begin
                busy_cycles++;
                chk("full_clr_wr", {wr_ready, ram_we, ram_addr, ram_din},
                    {1'b0, 1'b1, 15'(exp_cnt), 16'd400});
                exp_cnt++;
            end
            if (clear_done) begin
                done_cnt++;
                chk("done_wr_resume", {wr_ready, ram_we, ram_addr, ram_din},
                    {1'b1, 1'b1, 15'h0100, 16'hBEEF});
            end
        end
        @(posedge clk); #1;
        wr_valid = 1'b0;
        @(negedge clk);
        chk("done_single_pulse", {clear_done, clear_busy}, 2'b00);
        chk("full_busy_cycles",  busy_cycles, 32768);
        chk("full_done_count",   done_cnt,    1);
        chk("full_write_count",  exp_cnt,     32768);

        read_back(15'h0000, 16'd400,  "rb_addr0");
        read_back(15'h7FFF, 16'd400,  "rb_addr7fff");
        read_back(15'h4000, 16'd400,  "rb_addr4000");
        read_back(15'h0100, 16'hBEEF, "rb_done_write");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/wave_ram_arbiter.md
Name: wave_ram_arbiter

Overview:
- Sequences and shares the single-port wave sample RAM (32K x 16) between three users: the display read path, a sample-write requester (trace capture), and an internal clear engine.
- The clear engine fills the whole RAM with the midline value.
- Display reads have absolute priority and fixed latency, so the pixel pipeline never stalls.
- Sits between the picture/wave display block and the wave RAM instance; the capture logic drives the write port.

Parameters:
P_ADDR_W, 15, RAM address width
P_DATA_W, 16, RAM data width
P_DEPTH, 32768, number of words cleared (must be <= 2**P_ADDR_W)
P_CLEAR_VAL, 16'd400, value written by the clear engine (screen midline)
P_RD_LAT, 1, RAM read latency in cycles (1..3)

Ports:
I_sys_clk  in  1  system clock, all logic on rising edge
I_reset  in  1  synchronous active-high reset
I_clear_req  in  1  single-cycle pulse; start full-RAM clear
O_clear_busy  out  1  high while clear in progress
O_clear_done  out  1  one-cycle pulse after last clear write
I_rd_en  in  1  display read request this cycle
I_rd_addr  in  P_ADDR_W  display read address
O_rd_data  out  P_DATA_W  read data; 0 when O_rd_valid low
O_rd_valid  out  1  I_rd_en delayed by P_RD_LAT
I_wr_valid  in  1  write request
I_wr_addr  in  P_ADDR_W  write address
I_wr_data  in  P_DATA_W  write data
O_wr_ready  out  1  write accepted when I_wr_valid & O_wr_ready
O_ram_addr  out  P_ADDR_W  to RAM addra
O_ram_we  out  1  to RAM wea
O_ram_din  out  P_DATA_W  to RAM dia
I_ram_dout  in  P_DATA_W  from RAM doa

Behaviour:
- Reset values:
  - O_clear_busy=0, O_clear_done=0, O_rd_valid=0 (valid pipeline all 0).
  - O_wr_ready=0 while I_reset=1; O_rd_data=0.
  - State S_IDLE, clear counter 0.
- Clock and reset: one clock domain. Reset is synchronous and active-high (I_reset), sampled on the I_sys_clk rising edge.
- FSM states:
  - S_IDLE: I_clear_req -> S_CLEAR; counter=0.
  - S_CLEAR: a clear write is issued in every cycle with I_rd_en=0, and the counter increments.
    - The write at counter==P_DEPTH-1 -> S_DONE.
    - Cycles with I_rd_en=1 stall the counter (no write).
  - S_DONE: O_clear_done=1 for one cycle -> S_IDLE.
- O_clear_busy = (state==S_CLEAR).
- I_clear_req in S_CLEAR/S_DONE is ignored (not queued).
- Port mux, combinational, one RAM access per cycle, priority read > clear > write:
  - I_rd_en=1: O_ram_addr=I_rd_addr, O_ram_we=0.
  - Else S_CLEAR: addr=counter[P_ADDR_W-1:0], we=1, din=P_CLEAR_VAL.
  - Else I_wr_valid=1 (state S_IDLE or S_DONE): addr=I_wr_addr, we=1, din=I_wr_data.
  - Else: addr holds the last read address, we=0.
- O_wr_ready = ~I_reset & ~I_rd_en & (state!=S_CLEAR). It is combinational and may be low in arbitrary cycles. The requester holds valid, addr and data stable until the handshake.
- Read timing:
  - O_rd_valid = I_rd_en delayed exactly P_RD_LAT cycles through a shift register.
  - O_rd_data = O_rd_valid ? I_ram_dout : 0.
  - Throughput is 1 read/cycle; back-to-back reads are never blocked.
- A write and a read in the same cycle: the read wins, the write is not accepted (ready=0), and no data is lost.
- Clear counter width is P_ADDR_W+1, so P_DEPTH=2**P_ADDR_W terminates with no wrap.
- Reset mid-clear: aborts immediately; no O_clear_done pulse; RAM contents are partially cleared and undefined. Valid pipeline flushed to 0.
- A write accepted in the cycle that S_DONE is entered is impossible, because S_CLEAR blocks writes. Writes resume in S_DONE.

Decomposition:
- Shared package (wave_pkg): P_ADDR_W, P_DATA_W, P_DEPTH, P_CLEAR_VAL (16'd400), and the state encoding S_IDLE=2'd0, S_CLEAR=2'd1, S_DONE=2'd2.
- One natural sub-module: wave_clear_fsm, holding the state register, counter, busy/done flags and stall input; its outputs are the clear address and write strobe.
- The mux and valid pipeline stay in the top module.

Test Plan:
- Reset then idle, with I_rd_en=1 and I_rd_addr=15'h0010 over 4 cycles -> O_ram_we=0 and addresses pass through. O_rd_valid rises exactly P_RD_LAT cycles later; O_rd_data equals the RAM model words.
- I_wr_valid=1, addr=15'h0123, data=16'hABCD with I_rd_en=0 -> O_wr_ready=1, one write. A following read of 0x0123 returns 16'hABCD.
- Write held while I_rd_en=1 for 3 cycles -> O_wr_ready=0 for those cycles. The write is accepted on the first cycle with I_rd_en=0, and exactly one write occurs.
- Pulse I_clear_req with P_DEPTH=32768 and no reads -> 32768 writes of 16'd400 to addresses 0..32767. O_clear_busy high for 32768 cycles; O_clear_done pulses once; read-back of 0 and 32767 gives 400.
- Clear with I_rd_en=1 on alternate cycles -> clear takes 65536 cycles. Reads still return correct data with latency P_RD_LAT; O_wr_ready stays 0 throughout S_CLEAR; a second I_clear_req during clear is ignored.
- Assert I_reset at counter=1000 during clear -> next cycle O_clear_busy=0, no O_clear_done, O_rd_valid=0. A new I_clear_req restarts from address 0.
